hbridge_deadtime: RTL and testbench
===================================

HBRIDGE_DEADTIME -- requirements
Module: hbridge_deadtime

Interface
REQ-001 SHALL have parameter DEAD_CYCLES, default 8, number of clocks both gates of a leg are off between switching sides; legal range 1..255.
REQ-002 SHALL have parameter ADC_W, default 12, width of ADC and ADC_CMP.
REQ-003 SHALL have port CLK  input  1  single system clock; all state changes on the rising edge.
REQ-004 SHALL have port RESET_N  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ENABLE  input  1  bridge enable; low forces all gates off.
REQ-006 SHALL have port IN1  input  1  leg-1 high-side command, from the motor PWM OUT1.
REQ-007 SHALL have port IN2  input  1  leg-2 high-side command, from the motor PWM OUT2.
REQ-008 SHALL have port ADC  input  ADC_W  unsigned current sample.
REQ-009 SHALL have port ADC_CMP  input  ADC_W  unsigned overcurrent threshold.
REQ-010 SHALL have port ADC_VALID  input  1  one-cycle strobe marking ADC as valid.
REQ-011 SHALL have port FAULT_CLR  input  1  request to clear a latched fault.
REQ-012 SHALL have ports HS1, LS1, HS2, LS2  output  1 each  high/low-side gate drives, active high, registered.
REQ-013 SHALL have port FAULT  output  1  latched overcurrent flag.
REQ-014 SHALL have port FAULT_COUNT  output  8  count of overcurrent trips, saturating.

Function
REQ-015 SHALL register the commands each cycle: cmd1 = IN1 & !IN2, cmd2 = IN2 & !IN1; IN1=IN2 (both high or both low) sets both commands low.
REQ-016 SHALL run one independent state machine per leg with states OFF, DEAD, HIGH, LOW.
REQ-017 SHALL decode gates from state only: HIGH -> HS=1, LS=0; LOW -> HS=0, LS=1; OFF and DEAD -> HS=0, LS=0.
REQ-018 SHALL never assert HS and LS of the same leg in the same cycle.
REQ-019 SHALL move OFF -> DEAD when ENABLE=1 and FAULT=0.
REQ-020 SHALL move HIGH -> DEAD when the registered command is low, and LOW -> DEAD when it is high.
REQ-021 SHALL load the dead counter with DEAD_CYCLES-1 on DEAD entry and decrement it each cycle in DEAD.
REQ-022 SHALL, when DEAD and counter = 0, move to HIGH if the registered command is high, else LOW; DEAD therefore lasts exactly DEAD_CYCLES cycles.
REQ-023 SHALL complete the full dead time even if the command returns to the previous side during DEAD.
REQ-024 SHALL give this latency: IN change sampled at edge k -> old gate drops after edge k+1 -> new gate rises after edge k+1+DEAD_CYCLES.
REQ-025 SHALL force both legs to OFF on the next edge when ENABLE=0 or FAULT=1, from any state.
REQ-026 SHALL, on an edge with ADC_VALID=1 and ADC > ADC_CMP (unsigned, strict), set FAULT=1 and force both legs to OFF at that same edge.
REQ-027 SHALL increment FAULT_COUNT on each 0->1 transition of FAULT, saturating at 255; a trip while already faulted does not count.
REQ-028 SHALL clear FAULT on an edge with FAULT_CLR=1 unless a trip condition occurs on that edge, in which case the trip wins and FAULT stays 1.
REQ-029 SHALL clear FAULT_COUNT only by reset.
REQ-030 SHALL restart after a fault is cleared or ENABLE rises through OFF -> DEAD, so every restart observes the full dead time.

Reset
REQ-031 SHALL, while RESET_N=0, asynchronously force HS1=LS1=HS2=LS2=0, FAULT=0, FAULT_COUNT=0, both legs OFF, dead counters 0 and registered commands 0.
REQ-032 SHALL, on reset assertion mid-DEAD or mid-HIGH, drop gates immediately without waiting for a clock, and restart from OFF after release.

Verification
REQ-033 SHALL cover: ENABLE=1, IN1=1, IN2=0 from reset, DEAD_CYCLES=8 -> HS1=1, LS2=1 appear 8 cycles after leg DEAD entry, while HS2=0 and LS1=0.
REQ-034 SHALL cover: IN1/IN2 swap while steady -> HS1 drops 1 cycle after the command register updates, LS1 rises 8 cycles later, and HS1 and LS1 are never both 1.
REQ-035 SHALL cover: command toggles back mid-DEAD at cycle 3 -> gates stay off for all 8 cycles, then the original side returns.
REQ-036 SHALL cover: ADC=0x900, ADC_CMP=0x800, ADC_VALID pulse -> all gates 0 and FAULT=1 after that edge, FAULT_COUNT=1; ADC=0x800 (equal) -> no trip.
REQ-037 SHALL cover: FAULT_CLR and a trip on the same edge -> FAULT stays 1 and FAULT_COUNT is unchanged; a later FAULT_CLR alone -> FAULT=0, then the 8-cycle dead time, then gates resume.
REQ-038 SHALL cover: 300 separate trip/clear cycles -> FAULT_COUNT=255; RESET_N pulse mid-DEAD -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/hbridge_deadtime.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hbridge_deadtime: two-leg H-bridge gate driver with dead-time insertion  |
// | and latched ADC overcurrent trip.                                        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module hbridge_deadtime #(
  parameter int DEAD_CYCLES = 8,
  parameter int ADC_W       = 12
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             ENABLE,
  input  logic             IN1,
  input  logic             IN2,
  input  logic [ADC_W-1:0] ADC,
  input  logic [ADC_W-1:0] ADC_CMP,
  input  logic             ADC_VALID,
  input  logic             FAULT_CLR,
  output logic             HS1,
  output logic             LS1,
  output logic             HS2,
  output logic             LS2,
  output logic             FAULT,
  output logic [7:0]       FAULT_COUNT
);

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_DEAD = 2'd1,
    S_HIGH = 2'd2,
    S_LOW  = 2'd3
  } leg_state_t;

  localparam logic [7:0] c_DEAD_LOAD = 8'(DEAD_CYCLES - 1);

  logic       r_cmd1;
  logic       r_cmd2;
  logic [1:0] w_cmd;
  logic       r_fault;
  logic [7:0] r_fault_count;
  logic       w_trip;
  logic       w_force_off;

  assign w_trip      = ADC_VALID && (ADC > ADC_CMP);
  assign w_force_off = !ENABLE || r_fault || w_trip;
  assign w_cmd       = {r_cmd2, r_cmd1};

  // Equal commands are treated as "no side requested" so both legs pull low.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_cmd1 <= 1'b0;
      r_cmd2 <= 1'b0;
    end else begin
      r_cmd1 <= IN1 & ~IN2;
      r_cmd2 <= IN2 & ~IN1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_fault       <= 1'b0;
      r_fault_count <= 8'd0;
    end else begin
      if (w_trip) begin
        r_fault <= 1'b1;
        if (!r_fault && (r_fault_count != 8'hFF)) begin
          r_fault_count <= r_fault_count + 8'd1;
        end
      end else if (FAULT_CLR) begin
        r_fault <= 1'b0;
      end
    end
  end

  generate
    for (genvar g = 0; g < 2; g++) begin : g_leg
      leg_state_t r_state;
      leg_state_t w_state_nxt;
      logic [7:0] r_cnt;
      logic [7:0] w_cnt_nxt;
      logic       r_hs;
      logic       r_ls;

      always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (w_force_off) begin
          w_state_nxt = S_OFF;
          w_cnt_nxt   = 8'd0;
        end else begin
          case (r_state)
            S_OFF: begin
              w_state_nxt = S_DEAD;
              w_cnt_nxt   = c_DEAD_LOAD;
            end
            // The dead window always runs to completion, regardless of command.
            S_DEAD: begin
              if (r_cnt == 8'd0) begin
                w_state_nxt = w_cmd[g] ? S_HIGH : S_LOW;
              end else begin
                w_cnt_nxt = r_cnt - 8'd1;
              end
            end
            S_HIGH: begin
              if (!w_cmd[g]) begin
                w_state_nxt = S_DEAD;
                w_cnt_nxt   = c_DEAD_LOAD;
              end
            end
            S_LOW: begin
              if (w_cmd[g]) begin
                w_state_nxt = S_DEAD;
                w_cnt_nxt   = c_DEAD_LOAD;
              end
            end
            default: begin
              w_state_nxt = S_OFF;
              w_cnt_nxt   = 8'd0;
            end
          endcase
        end
      end

      // Gates are registered from the next state so they track the state register exactly.
      always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
          r_state <= S_OFF;
          r_cnt   <= 8'd0;
          r_hs    <= 1'b0;
          r_ls    <= 1'b0;
        end else begin
          r_state <= w_state_nxt;
          r_cnt   <= w_cnt_nxt;
          r_hs    <= (w_state_nxt == S_HIGH);
          r_ls    <= (w_state_nxt == S_LOW);
        end
      end
    end
  endgenerate

  assign HS1         = g_leg[0].r_hs;
  assign LS1         = g_leg[0].r_ls;
  assign HS2         = g_leg[1].r_hs;
  assign LS2         = g_leg[1].r_ls;
  assign FAULT       = r_fault;
  assign FAULT_COUNT = r_fault_count;

endmodule
`default_nettype wire

// File: tb/tb_hbridge_deadtime.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_hbridge_deadtime: scoreboard bench with a timestamp-based reference.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_hbridge_deadtime;

  localparam int c_D = 8;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b1;
  logic        ENABLE = 1'b0;
  logic        IN1 = 1'b0;
  logic        IN2 = 1'b0;
  logic [11:0] ADC = '0;
  logic [11:0] ADC_CMP = '0;
  logic        ADC_VALID = 1'b0;
  logic        FAULT_CLR = 1'b0;
  logic        HS1, LS1, HS2, LS2, FAULT;
  logic [7:0]  FAULT_COUNT;

  hbridge_deadtime #(.DEAD_CYCLES(c_D), .ADC_W(12)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .ENABLE(ENABLE), .IN1(IN1), .IN2(IN2),
    .ADC(ADC), .ADC_CMP(ADC_CMP), .ADC_VALID(ADC_VALID), .FAULT_CLR(FAULT_CLR),
    .HS1(HS1), .LS1(LS1), .HS2(HS2), .LS2(LS2), .FAULT(FAULT), .FAULT_COUNT(FAULT_COUNT)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       hs1, ls1, hs2, ls2, fault;
    logic [7:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference: each leg is idle, blanking until a cycle stamp, or conducting on a side.
  int cyc = 0;
  bit m_c1 = 0, m_c2 = 0, m_fault = 0;
  int m_cnt = 0;
  bit m_run[2], m_on[2], m_side[2];
  int m_settle[2];

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_c1 = 0; m_c2 = 0; m_fault = 0; m_cnt = 0;
    for (int l = 0; l < 2; l++) begin
      m_run[l] = 0; m_on[l] = 0; m_side[l] = 0; m_settle[l] = 0;
    end
  endtask

  task automatic model_edge(input bit en, i1, i2, input logic [11:0] adc, cmp,
                            input bit v, clr, output exp_t e);
    bit trip, force_off, cmd;
    cyc++;
    trip      = v && (adc > cmp);
    force_off = !en || m_fault || trip;
    for (int l = 0; l < 2; l++) begin
      cmd = (l == 0) ? m_c1 : m_c2;
      if (force_off) begin
        m_run[l] = 0; m_on[l] = 0;
      end else if (!m_run[l]) begin
        m_run[l] = 1; m_on[l] = 0; m_settle[l] = cyc + c_D;
      end else if (!m_on[l]) begin
        if (cyc == m_settle[l]) begin m_on[l] = 1; m_side[l] = cmd; end
      end else if (cmd != m_side[l]) begin
        m_on[l] = 0; m_settle[l] = cyc + c_D;
      end
    end
    if (trip) begin
      if (!m_fault && m_cnt < 255) m_cnt++;
      m_fault = 1;
    end else if (clr) begin
      m_fault = 0;
    end
    m_c1 = i1 & ~i2;
    m_c2 = i2 & ~i1;
    e.hs1 = m_on[0] & m_side[0];  e.ls1 = m_on[0] & ~m_side[0];
    e.hs2 = m_on[1] & m_side[1];  e.ls2 = m_on[1] & ~m_side[1];
    e.fault = m_fault;
    e.cnt   = 8'(m_cnt);
  endtask

  // Called at a negedge: drive inputs, predict the next edge, wait for the next negedge.
  task automatic step(input bit en, i1, i2, input logic [11:0] adc, cmp, input bit v, clr);
    exp_t e;
    ENABLE = en; IN1 = i1; IN2 = i2; ADC = adc; ADC_CMP = cmp; ADC_VALID = v; FAULT_CLR = clr;
    model_edge(en, i1, i2, adc, cmp, v, clr, e);
    q.push_back(e);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    #1;
    check("async_reset", {HS1, LS1, HS2, LS2, FAULT, FAULT_COUNT}, 13'h0);
    @(negedge CLK);
    RESET_N = 1'b1;
    model_reset();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("outputs", {HS1, LS1, HS2, LS2, FAULT, FAULT_COUNT}, 13'(e));
        check("leg1_overlap", {12'h0, HS1 & LS1}, 13'h0);
        check("leg2_overlap", {12'h0, HS2 & LS2}, 13'h0);
      end
    end
  end

  initial begin : driver
    bit ri1, ri2, ren, rv, rclr;
    logic [11:0] radc;
    model_reset();
    @(negedge CLK);
    do_reset();

    repeat (20) step(1, 1, 0, 12'h000, 12'h800, 0, 0);   // start-up dead time
    repeat (20) step(1, 0, 1, 12'h000, 12'h800, 0, 0);   // side swap
    repeat (3)  step(1, 1, 0, 12'h000, 12'h800, 0, 0);   // swap then revert mid-dead
    repeat (20) step(1, 0, 1, 12'h000, 12'h800, 0, 0);
    repeat (15) step(1, 1, 1, 12'h000, 12'h800, 0, 0);   // equal commands
    repeat (15) step(1, 0, 0, 12'h000, 12'h800, 0, 0);
    repeat (15) step(1, 1, 0, 12'h000, 12'h800, 0, 0);
    repeat (2)  step(0, 1, 0, 12'h000, 12'h800, 0, 0);   // enable drop
    repeat (15) step(1, 1, 0, 12'h000, 12'h800, 0, 0);
    step(1, 1, 0, 12'h800, 12'h800, 1, 0);               // equal -> no trip
    step(1, 1, 0, 12'hFFF, 12'h800, 0, 0);               // not valid -> no trip
    step(1, 1, 0, 12'h900, 12'h800, 1, 0);               // trip
    repeat (3)  step(1, 1, 0, 12'h000, 12'h800, 0, 0);
    step(1, 1, 0, 12'h900, 12'h800, 1, 1);               // clear + trip same edge
    repeat (3)  step(1, 1, 0, 12'h000, 12'h800, 0, 0);
    step(1, 1, 0, 12'h000, 12'h800, 0, 1);               // clear alone
    repeat (15) step(1, 1, 0, 12'h000, 12'h800, 0, 0);
    do_reset();                                          // reset mid-HIGH
    repeat (4)  step(1, 0, 1, 12'h000, 12'h800, 0, 0);
    do_reset();                                          // reset mid-DEAD
    repeat (12) step(1, 0, 1, 12'h000, 12'h800, 0, 0);

    ri1 = 1; ri2 = 0;
    repeat (500) begin
      if ($urandom_range(0, 29) == 0) begin ri1 = 1'($urandom); ri2 = 1'($urandom); end
      ren  = ($urandom_range(0, 59) != 0);
      rv   = ($urandom_range(0, 19) == 0);
      rclr = ($urandom_range(0, 24) == 0);
      radc = 12'($urandom);
      step(ren, ri1, ri2, radc, 12'h800, rv, rclr);
    end

    do_reset();
    repeat (300) begin
      step(1, 1, 0, 12'h900, 12'h800, 1, 0);
      step(1, 1, 0, 12'h000, 12'h800, 0, 1);
    end
    repeat (12) step(1, 1, 0, 12'h000, 12'h800, 0, 0);
    #2;
    check("fault_count_sat", {5'h0, FAULT_COUNT}, 13'd255);
    check("queue_drained", 13'(q.size()), 13'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
